busca_instrucao: RTL and testbench

Instruction-fetch stage of the 8-bit processor, directly upstream of the instruction memory. Holds the program counter, drives the memory address, and captures the returned byte into an instruction register (IR) for the decoder. Handles downstream stall, taken branches (one-cycle bubble), PC wrap-around and a HALT opcode that freezes fetch until reset.

---
 rtl/busca_instrucao.sv | 109 ++++++++++
 tb/tb_busca_instrucao.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: program counter, memory address, instruction register.
// Registered-read memory; handles stall replay, taken branches and HALT.
module busca_instrucao #(
    parameter int                 LARGURA     = 8,
    parameter logic [LARGURA-1:0] OPCODE_HALT = 8'hFF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [LARGURA-1:0] Instrucao,
    input  logic               Stall,
    input  logic               DesvioValido,
    input  logic [LARGURA-1:0] DesvioAlvo,
    output logic [LARGURA-1:0] Endereco,
    output logic [LARGURA-1:0] InstrucaoIR,
    output logic [LARGURA-1:0] PCIR,
    output logic               ValidoIR,
    output logic               Parado
);

    typedef enum logic [1:0] {
        INICIO,
        BUSCA,
        PARADO
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] pc_q, pc_d;
    logic [LARGURA-1:0] voo_q, voo_d;
    logic [LARGURA-1:0] ir_q, ir_d;
    logic [LARGURA-1:0] pcir_q, pcir_d;
    logic               valido_q, valido_d;
    logic [LARGURA-1:0] endereco;

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        voo_d    = voo_q;
        ir_d     = ir_q;
        pcir_d   = pcir_q;
        valido_d = valido_q;
        endereco = pc_q;

        unique case (estado_q)
            INICIO: begin
                voo_d    = pc_q;
                pc_d     = pc_q + 1'b1;
                estado_d = BUSCA;
            end

            BUSCA: begin
                if (DesvioValido) begin
                    // In-flight byte belongs to the wrong path: drop it.
                    endereco = DesvioAlvo;
                    valido_d = 1'b0;
                    voo_d    = DesvioAlvo;
                    pc_d     = DesvioAlvo + 1'b1;
                end else if (Stall) begin
                    // Re-present the pending address so the byte survives.
                    endereco = voo_q;
                end else begin
                    endereco = pc_q;
                    ir_d     = Instrucao;
                    pcir_d   = voo_q;
                    valido_d = 1'b1;
                    voo_d    = pc_q;
                    pc_d     = pc_q + 1'b1;
                    if (Instrucao == OPCODE_HALT) begin
                        estado_d = PARADO;
                    end
                end
            end

            PARADO: begin
                if (!Stall) begin
                    valido_d = 1'b0;
                end
            end

            default: begin
                estado_d = INICIO;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q <= INICIO;
            pc_q     <= '0;
            voo_q    <= '0;
            ir_q     <= '0;
            pcir_q   <= '0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            voo_q    <= voo_d;
            ir_q     <= ir_d;
            pcir_q   <= pcir_d;
            valido_q <= valido_d;
        end
    end

    assign Endereco    = endereco;
    assign InstrucaoIR = ir_q;
    assign PCIR        = pcir_q;
    assign ValidoIR    = valido_q;
    assign Parado      = (estado_q == PARADO);

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao with a registered-read memory model.
module tb_busca_instrucao;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Instrucao;
    logic       Stall = 1'b0;
    logic       DesvioValido = 1'b0;
    logic [7:0] DesvioAlvo = 8'h00;
    logic [7:0] Endereco;
    logic [7:0] InstrucaoIR;
    logic [7:0] PCIR;
    logic       ValidoIR;
    logic       Parado;

    logic       halt_en = 1'b0;
    logic [7:0] mem_q = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    busca_instrucao #(
        .LARGURA(8),
        .OPCODE_HALT(8'hFF)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Instrucao(Instrucao),
        .Stall(Stall),
        .DesvioValido(DesvioValido),
        .DesvioAlvo(DesvioAlvo),
        .Endereco(Endereco),
        .InstrucaoIR(InstrucaoIR),
        .PCIR(PCIR),
        .ValidoIR(ValidoIR),
        .Parado(Parado)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        if (a == 8'hFF) return 8'h3C;
        if (a == 8'h10) return halt_en ? 8'hFF : 8'h10;
        return a;
    endfunction

    always @(posedge Clock) mem_q <= mem_rd(Endereco);
    assign Instrucao = mem_q;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] ir,
                          input logic [7:0] pc, input logic v);
        chk({tag, ".ir"}, InstrucaoIR, ir);
        chk({tag, ".pcir"}, PCIR, pc);
        chk({tag, ".valido"}, {7'd0, ValidoIR}, {7'd0, v});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".end"}, Endereco, 8'h00);
        chk_ir(tag, 8'h00, 8'h00, 1'b0);
        chk({tag, ".parado"}, {7'd0, Parado}, 8'h00);
    endtask

    // Reset, release before E1, stop just after E2.
    task automatic restart(input string tag);
        Reset = 1'b0;
        #1;
        chk_zero({tag, ".rst"});
        @(negedge Clock);
        Reset = 1'b1;
        step();
        chk({tag, ".e1.valido"}, {7'd0, ValidoIR}, 8'h00);
        chk({tag, ".e1.end"}, Endereco, 8'h01);
        step();
        chk_ir({tag, ".e2"}, 8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        // Startup from power-on reset
        #1;
        chk_zero("por");
        @(negedge Clock);
        Reset = 1'b1;
        step();
        chk("e1.valido", {7'd0, ValidoIR}, 8'h00);
        chk("e1.end", Endereco, 8'h01);
        step();
        chk_ir("e2", 8'h00, 8'h00, 1'b1);
        step();
        step();
        step();
        chk_ir("e5", 8'h03, 8'h03, 1'b1);
        step();
        step();
        chk_ir("e7", 8'h05, 8'h05, 1'b1);

        // Stall three cycles at IR=05
        Stall = 1'b1;
        #1;
        chk("stall.end", Endereco, 8'h06);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ir("stall.hold", 8'h05, 8'h05, 1'b1);
            chk("stall.end_hold", Endereco, 8'h06);
        end
        Stall = 1'b0;
        step();
        chk_ir("stall.rel0", 8'h06, 8'h06, 1'b1);
        step();
        chk_ir("stall.rel1", 8'h07, 8'h07, 1'b1);

        // Asynchronous reset between edges while IR=07
        #2;
        Reset = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge Clock);
        Reset = 1'b1;
        step();
        chk("midrst.e1.valido", {7'd0, ValidoIR}, 8'h00);
        step();
        chk_ir("midrst.e2", 8'h00, 8'h00, 1'b1);

        // Branch taken at IR=04
        for (int i = 0; i < 4; i++) step();
        chk_ir("br.pre", 8'h04, 8'h04, 1'b1);
        DesvioValido = 1'b1;
        DesvioAlvo = 8'h40;
        #1;
        chk("br.end", Endereco, 8'h40);
        step();
        DesvioValido = 1'b0;
        chk_ir("br.bubble", 8'h04, 8'h04, 1'b0);
        step();
        chk_ir("br.t0", 8'h40, 8'h40, 1'b1);
        step();
        chk_ir("br.t1", 8'h41, 8'h41, 1'b1);

        // Same branch with Stall asserted in the branch cycle
        restart("brs");
        for (int i = 0; i < 4; i++) step();
        chk_ir("brs.pre", 8'h04, 8'h04, 1'b1);
        DesvioValido = 1'b1;
        Stall = 1'b1;
        DesvioAlvo = 8'h40;
        #1;
        chk("brs.end", Endereco, 8'h40);
        step();
        DesvioValido = 1'b0;
        Stall = 1'b0;
        chk_ir("brs.bubble", 8'h04, 8'h04, 1'b0);
        step();
        chk_ir("brs.t0", 8'h40, 8'h40, 1'b1);
        step();
        chk_ir("brs.t1", 8'h41, 8'h41, 1'b1);

        // Wrap-around past 8'hFF
        DesvioValido = 1'b1;
        DesvioAlvo = 8'hFE;
        step();
        DesvioValido = 1'b0;
        chk_ir("wrap.bubble", 8'h41, 8'h41, 1'b0);
        step();
        chk_ir("wrap.fe", 8'hFE, 8'hFE, 1'b1);
        step();
        chk_ir("wrap.ff", 8'h3C, 8'hFF, 1'b1);
        step();
        chk_ir("wrap.00", 8'h00, 8'h00, 1'b1);
        step();
        chk_ir("wrap.01", 8'h01, 8'h01, 1'b1);

        // HALT at address 10
        halt_en = 1'b1;
        restart("halt");
        for (int i = 1; i < 16; i++) begin
            step();
            chk("halt.run", InstrucaoIR, 8'(i));
        end
        step();
        chk_ir("halt.ld", 8'hFF, 8'h10, 1'b1);
        chk("halt.parado", {7'd0, Parado}, 8'h01);
        chk("halt.end", Endereco, 8'h12);
        Stall = 1'b1;
        step();
        chk_ir("halt.stall", 8'hFF, 8'h10, 1'b1);
        Stall = 1'b0;
        DesvioValido = 1'b1;
        DesvioAlvo = 8'h40;
        #1;
        chk("halt.end_br", Endereco, 8'h12);
        step();
        chk_ir("halt.clr", 8'hFF, 8'h10, 1'b0);
        chk("halt.end_fz", Endereco, 8'h12);
        DesvioValido = 1'b0;
        step();
        chk_ir("halt.stay", 8'hFF, 8'h10, 1'b0);
        chk("halt.parado2", {7'd0, Parado}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
